ifetch_unit: RTL and testbench

//  Instruction-fetch front end for the miniRV core: owns the PC, requests words

---
 rtl/ifetch_if.sv | 27 ++
 rtl/ifetch_unit.sv | 99 +++++++++
 tb/tb_ifetch_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decoder-side
// instruction handshake and redirect inputs.
interface ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_accept;
  logic        pc_sel;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;
  logic [31:0] retired;

  modport master (
    output imem_req, imem_addr, ins, ins_valid, pc, pc_plus4, misalign, retired,
    input  imem_rvalid, imem_rdata, ins_accept, pc_sel, br_target
  );

  modport slave (
    input  imem_req, imem_addr, ins, ins_valid, pc, pc_plus4, misalign, retired,
    output imem_rvalid, imem_rdata, ins_accept, pc_sel, br_target
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches one word per instruction,
// re-requests after a silent memory and forms the next PC on retirement.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input logic      clk,
  input logic      rst_n,
  ifetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // WAIT lasts TIMEOUT-1 cycles, so the re-request lands TIMEOUT cycles after the first
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, VALID} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] addr_reg;
  logic        req_reg;
  logic [31:0] ins_reg;
  logic        ins_valid_reg;
  logic        misalign_reg;
  logic [31:0] retired_reg;
  logic [CW-1:0] cnt_reg;
  logic [31:0] pc_next;

  always_comb begin
    pc_next = pc_reg + 32'd4;
    if (bus.pc_sel) begin
      pc_next = {bus.br_target[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      addr_reg      <= RESET_PC;
      req_reg       <= 1'b0;
      ins_reg       <= NOP;
      ins_valid_reg <= 1'b0;
      misalign_reg  <= 1'b0;
      retired_reg   <= 32'd0;
      cnt_reg       <= '0;
    end else begin
      req_reg      <= 1'b0;
      misalign_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          state_reg <= FETCH;
          req_reg   <= 1'b1;
          addr_reg  <= pc_reg;
        end
        FETCH: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            ins_reg       <= bus.imem_rdata;
            ins_valid_reg <= 1'b1;
            state_reg     <= VALID;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= FETCH;
            req_reg   <= 1'b1;
            addr_reg  <= pc_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        VALID: begin
          if (bus.ins_accept) begin
            pc_reg        <= pc_next;
            addr_reg      <= pc_next;
            req_reg       <= 1'b1;
            misalign_reg  <= bus.pc_sel & (|bus.br_target[1:0]);
            retired_reg   <= retired_reg + 32'd1;
            ins_valid_reg <= 1'b0;
            state_reg     <= FETCH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.imem_req  = req_reg;
  assign bus.imem_addr = addr_reg;
  assign bus.ins       = ins_reg;
  assign bus.ins_valid = ins_valid_reg;
  assign bus.pc        = pc_reg;
  assign bus.pc_plus4  = pc_reg + 32'd4;
  assign bus.misalign  = misalign_reg;
  assign bus.retired   = retired_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: expected fetch addresses are queued when an
// accept is driven and popped when the unit raises imem_req.
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_if a ();
  ifetch_if b ();

  ifetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] exp_ret;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for a request, match it against the scoreboard, answer one cycle later.
  task automatic fetch(input logic [31:0] data);
    int n = 0;
    logic [31:0] exp;
    while (!a.imem_req && n < 40) begin
      step();
      n++;
    end
    chk("req_seen", {31'd0, a.imem_req}, 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
    chk("fetch_addr", a.imem_addr, exp);
    step();
    chk("req_pulse", {31'd0, a.imem_req}, 32'd0);
    chk("misalign_low", {31'd0, a.misalign}, 32'd0);
    a.imem_rvalid = 1'b1;
    a.imem_rdata  = data;
    step();
    a.imem_rvalid = 1'b0;
    a.imem_rdata  = '0;
    chk("ins_valid", {31'd0, a.ins_valid}, 32'd1);
    chk("ins", a.ins, data);
    chk("pc", a.pc, m_pc);
    $display("fetch addr=%h ins=%h pc=%h", exp, a.ins, a.pc);
  endtask

  task automatic accept(input logic sel, input logic [31:0] tgt, input logic exp_mis);
    logic [31:0] nxt;
    nxt = sel ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
    a.ins_accept = 1'b1;
    a.pc_sel     = sel;
    a.br_target  = tgt;
    exp_q.push_back(nxt);
    m_pc = nxt;
    exp_ret = exp_ret + 32'd1;
    step();
    a.ins_accept = 1'b0;
    a.pc_sel     = 1'b0;
    a.br_target  = '0;
    chk("misalign", {31'd0, a.misalign}, {31'd0, exp_mis});
    chk("retired", a.retired, exp_ret);
    chk("pc_after_accept", a.pc, m_pc);
    chk("ins_valid_clr", {31'd0, a.ins_valid}, 32'd0);
    $display("accept sel=%0d tgt=%h next_pc=%h retired=%0d", sel, tgt, nxt, exp_ret);
  endtask

  initial begin
    int n;
    a.imem_rvalid = 0; a.imem_rdata = 0; a.ins_accept = 0; a.pc_sel = 0; a.br_target = 0;
    b.imem_rvalid = 0; b.imem_rdata = 0; b.ins_accept = 0; b.pc_sel = 0; b.br_target = 0;
    step();
    step();
    chk("rst_pc", a.pc, 32'd0);
    chk("rst_addr", a.imem_addr, 32'd0);
    chk("rst_req", {31'd0, a.imem_req}, 32'd0);
    chk("rst_ins", a.ins, 32'h0000_0013);
    chk("rst_ins_valid", {31'd0, a.ins_valid}, 32'd0);
    chk("rst_misalign", {31'd0, a.misalign}, 32'd0);
    chk("rst_retired", a.retired, 32'd0);
    chk("rst_pc_b", b.pc, 32'hFFFF_FFFC);
    chk("rst_pc4_b", b.pc_plus4, 32'd0);

    // High reset PC: sequential accept wraps to address 0.
    rst_n = 1'b1;
    step();
    chk("b_req", {31'd0, b.imem_req}, 32'd1);
    chk("b_addr", b.imem_addr, 32'hFFFF_FFFC);
    step();
    b.imem_rvalid = 1'b1;
    b.imem_rdata  = 32'h0000_006F;
    step();
    b.imem_rvalid = 1'b0;
    chk("b_ins", b.ins, 32'h0000_006F);
    chk("b_ins_valid", {31'd0, b.ins_valid}, 32'd1);
    b.ins_accept = 1'b1;
    step();
    b.ins_accept = 1'b0;
    chk("b_wrap_req", {31'd0, b.imem_req}, 32'd1);
    chk("b_wrap_addr", b.imem_addr, 32'd0);
    chk("b_wrap_pc", b.pc, 32'd0);
    chk("b_retired", b.retired, 32'd1);
    $display("dut1 wrap fetch addr=%h", b.imem_addr);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_pc = 32'd0;
    exp_ret = 32'd0;
    exp_q.delete();

    // Reset to first instruction with a 1-cycle memory.
    exp_q.push_back(32'd0);
    fetch(32'h0050_0093);
    chk("pc_plus4", a.pc_plus4, 32'd4);

    // Sequential retirement.
    accept(1'b0, 32'h0, 1'b0); fetch(32'h0010_0113);
    accept(1'b0, 32'h0, 1'b0); fetch(32'h0020_0193);
    accept(1'b0, 32'h0, 1'b0); fetch(32'h0030_0213);
    chk("retired3", a.retired, 32'd3);
    accept(1'b0, 32'h0, 1'b0); fetch(32'h0040_0293);

    // Taken jump and misaligned target.
    accept(1'b1, 32'h0000_0100, 1'b0); fetch(32'h0000_0013);
    accept(1'b1, 32'h0000_0103, 1'b1);
    step();
    chk("misalign_pulse", {31'd0, a.misalign}, 32'd0);
    a.imem_rvalid = 1'b1;
    a.imem_rdata  = 32'h0000_0033;
    step();
    a.imem_rvalid = 1'b0;
    chk("mis_ins", a.ins, 32'h0000_0033);
    chk("mis_pc", a.pc, 32'h0000_0100);
    void'(exp_q.pop_front());

    // Timeout: withheld response, accept while not valid must be ignored.
    accept(1'b0, 32'h0, 1'b0);
    chk("to_first_addr", a.imem_addr, 32'h0000_0104);
    a.ins_accept = 1'b1;
    a.pc_sel     = 1'b1;
    a.br_target  = 32'h0000_2000;
    n = 0;
    do begin
      step();
      n++;
    end while (!a.imem_req && n < 20);
    a.ins_accept = 1'b0;
    a.pc_sel     = 1'b0;
    a.br_target  = '0;
    chk("timeout_gap", n, 32'd8);
    chk("to_retired", a.retired, exp_ret);
    chk("to_pc", a.pc, 32'h0000_0104);
    $display("timeout re-request after %0d cycles addr=%h", n, a.imem_addr);
    fetch(32'h0000_0073);

    // Wrap from 0xFFFF_FFFC, then reset mid-WAIT with a stale response.
    accept(1'b1, 32'hFFFF_FFFC, 1'b0); fetch(32'h0000_00B3);
    chk("wrap_pc4", a.pc_plus4, 32'd0);
    accept(1'b0, 32'h0, 1'b0);
    chk("wrap_addr", a.imem_addr, 32'd0);
    void'(exp_q.pop_front());
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, a.ins_valid}, 32'd0);
    chk("mid_rst_pc", a.pc, 32'd0);
    chk("mid_rst_retired", a.retired, 32'd0);
    chk("mid_rst_ins", a.ins, 32'h0000_0013);
    step();
    rst_n = 1'b1;
    a.imem_rvalid = 1'b1;
    a.imem_rdata  = 32'hDEAD_BEEF;
    step();
    chk("post_rst_req", {31'd0, a.imem_req}, 32'd1);
    chk("post_rst_addr", a.imem_addr, 32'd0);
    step();
    a.imem_rvalid = 1'b0;
    a.imem_rdata  = '0;
    chk("stale_ignored", {31'd0, a.ins_valid}, 32'd0);
    chk("stale_ins", a.ins, 32'h0000_0013);
    a.imem_rvalid = 1'b1;
    a.imem_rdata  = 32'h0000_0113;
    step();
    a.imem_rvalid = 1'b0;
    chk("post_rst_ins", a.ins, 32'h0000_0113);
    chk("post_rst_valid", {31'd0, a.ins_valid}, 32'd1);
    $display("post-reset fetch ins=%h", a.ins);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
